// File: rtl/mem_if_pkg.sv
// Shared constants and state encoding for the 256-bit cache-line memory interface.
// Both the data-cache initiator and the line memory responder import these.
package mem_if_pkg;

  localparam int unsigned LINE_W   = 256;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/line_ram.sv
// DEPTH x LINE_W line store with synchronous write and synchronous read.
// Ports: clk, we (write strobe), re (read strobe), idx (line index),
//        wdata (line to store), rdata (registered read line, holds between reads).
module line_ram
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH];

  // Contents are never cleared; reset only affects the controller.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata    <= mem[idx];
  end

endmodule

// File: rtl/line_memory_responder.sv
// Responder for the CPU data cache line interface: accepts one line read/write
// at a time and completes it with a single-cycle ack after LATENCY edges.
// Ports: clk_i, rst_i (sync, active-low), mem_enable_i/mem_write_i/mem_addr_i/
//        mem_data_i (request), mem_data_o (read line, valid during ack), mem_ack_o.
module line_memory_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_enable_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_ack_o
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(LATENCY) + 1;
  localparam bit          SINGLE = (LATENCY == 32'd1);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] data_q;
  logic              ack_q;
  logic              rd_valid_q;
  logic              cap_c;
  logic              enter_ack_c;
  logic              req_wr_c;
  logic [IDX_W-1:0]  req_idx_c;
  logic [LINE_W-1:0] req_data_c;
  logic              ram_we_c;
  logic              ram_re_c;
  logic [LINE_W-1:0] ram_rdata;
  logic              unused_c;

  // Offset bits and address bits above the index field do not select a line.
  assign unused_c = ^mem_addr_i;

  // Next state, counter and capture/commit strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_c       = 1'b0;
    enter_ack_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_enable_i) begin
          cap_c = 1'b1;
          if (SINGLE) begin
            state_d     = ACK;
            enter_ack_c = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = ACK;
          enter_ack_c = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY = 1 the ACK entry coincides with capture, so use live inputs.
  assign req_wr_c   = (state_q == IDLE) ? mem_write_i                   : wr_q;
  assign req_idx_c  = (state_q == IDLE) ? mem_addr_i[OFFSET_W +: IDX_W] : idx_q;
  assign req_data_c = (state_q == IDLE) ? mem_data_i                    : data_q;

  // Reset on the ACK-entry edge must abort the commit as well.
  assign ram_we_c = rst_i & enter_ack_c &  req_wr_c;
  assign ram_re_c = rst_i & enter_ack_c & ~req_wr_c;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
      ack_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= enter_ack_c;
      if (ram_re_c) rd_valid_q <= 1'b1;
      if (cap_c) begin
        wr_q   <= mem_write_i;
        idx_q  <= mem_addr_i[OFFSET_W +: IDX_W];
        data_q <= mem_data_i;
      end
    end
  end

  line_ram #(.DEPTH(DEPTH)) u_line_ram (
    .clk   (clk_i),
    .we    (ram_we_c),
    .re    (ram_re_c),
    .idx   (req_idx_c),
    .wdata (req_data_c),
    .rdata (ram_rdata)
  );

  // The RAM read register has no reset; mask it until the first read after reset.
  assign mem_data_o = rd_valid_q ? ram_rdata : '0;
  assign mem_ack_o  = ack_q;

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed, scoreboard-based bench for line_memory_responder. Instance 0 uses
// LATENCY = 10, instance 1 uses LATENCY = 1; both use DEPTH = 512.
module tb_line_memory_responder;

  localparam int unsigned DEPTH = 512;

  logic         clk;
  logic         rst;
  logic         en    [2];
  logic         wr    [2];
  logic [31:0]  addr  [2];
  logic [255:0] wdata [2];
  logic [255:0] rdata [2];
  logic         ack   [2];

  int           checks;
  int           errors;
  int           lat [2];
  logic [255:0] model [int];
  logic [255:0] last_rd [2];
  logic [255:0] sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  line_memory_responder #(.DEPTH(DEPTH), .LATENCY(10)) u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mem_enable_i (en[0]),
    .mem_write_i  (wr[0]),
    .mem_addr_i   (addr[0]),
    .mem_data_i   (wdata[0]),
    .mem_data_o   (rdata[0]),
    .mem_ack_o    (ack[0])
  );

  line_memory_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk_i        (clk),
    .rst_i        (rst),
    .mem_enable_i (en[1]),
    .mem_write_i  (wr[1]),
    .mem_addr_i   (addr[1]),
    .mem_data_i   (wdata[1]),
    .mem_data_o   (rdata[1]),
    .mem_ack_o    (ack[1])
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int key(input int d, input logic [31:0] a);
    return d * 1024 + int'((a >> 5) % DEPTH);
  endfunction

  // One request with enable held until ack; optionally disturb inputs after capture.
  task automatic do_req(input int d, input bit w, input logic [31:0] a,
                        input logic [255:0] dat, input bit wiggle, input string tag);
    bit           got;
    int           at;
    logic [255:0] exp;
    @(negedge clk);
    en[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = dat;
    if (w) begin
      model[key(d, a)] = dat;
      sb.push_back(last_rd[d]);
    end else begin
      last_rd[d] = model[key(d, a)];
      sb.push_back(last_rd[d]);
    end
    @(posedge clk);
    #1;
    if (wiggle) begin
      wr[d] = ~w; wdata[d] = ~dat; addr[d] = a ^ 32'h20;
    end
    got = 1'b0;
    at  = -1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) tick();
      if (ack[d]) begin
        got = 1'b1;
        at  = k;
        break;
      end
    end
    en[d] = 1'b0;
    check({tag, "_ack_edge"}, 256'(at), 256'(lat[d] - 1));
    if (got) begin
      exp = sb.pop_front();
      check({tag, "_data"}, rdata[d], exp);
      tick();
      check({tag, "_ack_drop"}, 256'(ack[d]), 256'(0));
    end else begin
      void'(sb.pop_front());
    end
  endtask

  // Enable held high across several back-to-back reads of one line.
  task automatic held_reads(input int d, input logic [31:0] a, input int npulse, input string tag);
    int   pulses;
    logic prev;
    logic expack;
    int   last_k;
    logic [255:0] exp;
    last_k = (lat[d] - 1) + (npulse - 1) * (lat[d] + 1);
    last_rd[d] = model[key(d, a)];
    for (int i = 0; i < npulse; i++) sb.push_back(last_rd[d]);
    @(negedge clk);
    en[d] = 1'b1; wr[d] = 1'b0; addr[d] = a; wdata[d] = '0;
    @(posedge clk);
    #1;
    pulses = 0;
    prev   = 1'b0;
    for (int k = 0; k <= last_k; k++) begin
      if (k > 0) tick();
      expack = (k >= lat[d] - 1) && (((k - (lat[d] - 1)) % (lat[d] + 1)) == 0);
      check({tag, "_ack_pattern"}, 256'(ack[d]), 256'(expack));
      if (prev && ack[d]) check({tag, "_adjacent"}, 256'(1), 256'(0));
      if (ack[d]) begin
        pulses++;
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        check({tag, "_data"}, rdata[d], exp);
      end
      prev = ack[d];
    end
    en[d] = 1'b0;
    check({tag, "_pulse_count"}, 256'(pulses), 256'(npulse));
    while (sb.size() > 0) void'(sb.pop_front());
    tick();
    check({tag, "_ack_drop"}, 256'(ack[d]), 256'(0));
  endtask

  initial begin
    logic [255:0] pat_a, pat_b, pat_c, pat_d, pat_e;
    checks = 0;
    errors = 0;
    lat[0] = 10;
    lat[1] = 1;
    pat_a  = {8{32'hA5A5_0F0F}};
    pat_b  = {8{32'hBBBB_0000}};
    pat_c  = {4{64'h0123_4567_89AB_CDEF}};
    pat_d  = {16{16'h7E81}};
    pat_e  = {8{32'h1357_9BDF}};
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      last_rd[d] = '0;
    end

    // Reset for two edges, then idle.
    rst = 1'b0;
    tick();
    tick();
    check("reset_ack", 256'(ack[0]), 256'(0));
    check("reset_data", rdata[0], '0);
    check("reset_ack_l1", 256'(ack[1]), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_ack", 256'(ack[0]), 256'(0));
      check("idle_data", rdata[0], '0);
    end

    // Write then read same line.
    do_req(0, 1'b1, 32'h0000_0040, {8{32'hDEAD_BEEF}}, 1'b0, "wr_40");
    do_req(0, 1'b0, 32'h0000_0040, '0, 1'b0, "rd_40");

    // Offset bits ignored, upper bits wrap.
    do_req(0, 1'b1, 32'h0000_005F, pat_a, 1'b0, "wr_5f");
    do_req(0, 1'b0, 32'h0000_0040, '0, 1'b0, "rd_40_a");
    do_req(0, 1'b0, 32'h0000_4040, '0, 1'b0, "rd_4040_wrap");

    // Inputs changing after capture have no effect.
    do_req(0, 1'b1, 32'h0000_0100, pat_d, 1'b1, "wr_100_wiggle");
    do_req(0, 1'b0, 32'h0000_0100, '0, 1'b1, "rd_100_wiggle");
    do_req(0, 1'b0, 32'h0000_0120, '0, 1'b0, "rd_120_untouched");

    // Held enable through back-to-back reads.
    held_reads(0, 32'h0000_0040, 3, "held");

    // Reset mid-write aborts the commit and the ack.
    do_req(0, 1'b1, 32'h0000_0080, pat_c, 1'b0, "wr_80_c");
    @(negedge clk);
    en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_0080; wdata[0] = pat_b;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      check("abort_no_ack", 256'(ack[0]), 256'(0));
    end
    rst = 1'b0;
    en[0] = 1'b0;
    tick();
    check("abort_ack", 256'(ack[0]), 256'(0));
    check("abort_data_cleared", rdata[0], '0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst = (i >= 1);
      #1;
      check("abort_quiet", 256'(ack[0]), 256'(0));
    end
    do_req(0, 1'b0, 32'h0000_0080, '0, 1'b0, "rd_80_after_abort");

    // LATENCY = 1 instance.
    do_req(1, 1'b1, 32'h0000_0020, pat_e, 1'b0, "l1_wr_20");
    do_req(1, 1'b0, 32'h0000_0020, '0, 1'b0, "l1_rd_20");
    do_req(1, 1'b1, 32'h0000_403F, pat_a, 1'b1, "l1_wr_wrap");
    do_req(1, 1'b0, 32'h0000_0020, '0, 1'b0, "l1_rd_wrap");
    held_reads(1, 32'h0000_0020, 3, "l1_held");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
